// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU issue queue.
package alu_pkg;

  localparam int unsigned OPND_W = 8;
  localparam int unsigned RES_W  = 16;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [SEL_W-1:0] {
    OP_NOTA = 3'b000,
    OP_OR   = 3'b001,
    OP_AND  = 3'b010,
    OP_XOR  = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101,
    OP_MUL  = 3'b110,
    OP_NOTB = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e             sel;
    logic [OPND_W-1:0]   b;
    logic [OPND_W-1:0]   a;
  } alu_cmd_t;

  localparam int unsigned CMD_W = $bits(alu_cmd_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of two), combinational head read.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, not reset: occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/alu_issue_queue.sv
// ALU issue queue: buffers tagged commands, drives an external combinational
// ALU from the FIFO head and registers its result behind a valid/ready stage.
// Optional build macro ALU_ISSUE_STATS_EN adds op_count (saturating count of
// completed result handshakes).
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_A,
  input  logic [7:0]         in_B,
  input  logic [2:0]         in_Sel,
  output logic [7:0]         A,
  output logic [7:0]         B,
  output logic [2:0]         Sel,
  input  logic [15:0]        Y,
  input  logic               Cout,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [15:0]        res_Y,
  output logic               res_Cout,
  output logic [2:0]         res_Sel,
  output logic [TAG_W-1:0]   res_tag
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]        op_count
`endif
);

  localparam int unsigned ENTRY_W = TAG_W + CMD_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_empty_nxt;
  logic               w_res_valid_nxt;
  logic               w_hold;
  alu_cmd_t           w_in_cmd;
  alu_cmd_t           w_head_cmd;
  logic [ENTRY_W-1:0] w_in_entry;
  logic [ENTRY_W-1:0] w_head;
  logic [TAG_W-1:0]   w_head_tag;

  logic [TAG_W-1:0]   r_tag;
  logic               r_res_valid;
  logic [RES_W-1:0]   r_res_Y;
  logic               r_res_Cout;
  logic [SEL_W-1:0]   r_res_Sel;
  logic [TAG_W-1:0]   r_res_tag;
  state_e             r_state;
  state_e             w_state_nxt;

  assign w_in_cmd   = '{sel: alu_op_e'(in_Sel), b: in_B, a: in_A};
  assign w_in_entry = {r_tag, w_in_cmd};
  assign w_head_cmd = alu_cmd_t'(w_head[CMD_W-1:0]);
  assign w_head_tag = w_head[ENTRY_W-1:CMD_W];

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_in_entry),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Head operands go to the ALU; zero when nothing is queued.
  assign A        = w_empty ? '0 : w_head_cmd.a;
  assign B        = w_empty ? '0 : w_head_cmd.b;
  assign Sel      = w_empty ? '0 : SEL_W'(w_head_cmd.sel);
  assign in_ready = !w_full;

  // Handshake decode: accept when not full, pop when the result stage frees up.
  always_comb begin
    w_push = 1'b0;
    w_pop  = 1'b0;
    w_push = in_valid && !w_full;
    w_pop  = !w_empty && (!r_res_valid || res_ready);
  end

  // Tag counter advances once per accepted command and wraps.
  always_ff @(posedge clk) begin
    if (rst)         r_tag <= '0;
    else if (w_push) r_tag <= r_tag + TAG_W'(1);
  end

  // Result stage: capture on pop, clear on drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_Y     <= '0;
      r_res_Cout  <= 1'b0;
      r_res_Sel   <= '0;
      r_res_tag   <= '0;
    end else if (w_pop) begin
      r_res_valid <= 1'b1;
      r_res_Y     <= Y;
      r_res_Cout  <= Cout;
      r_res_Sel   <= SEL_W'(w_head_cmd.sel);
      r_res_tag   <= w_head_tag;
    end else if (r_res_valid && res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid = r_res_valid;
  assign res_Y     = r_res_Y;
  assign res_Cout  = r_res_Cout;
  assign res_Sel   = r_res_Sel;
  assign res_tag   = r_res_tag;

  // Post-edge occupancy/handshake view used to steer the tracking FSM.
  assign w_count_nxt     = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_empty_nxt     = (w_count_nxt == '0);
  assign w_res_valid_nxt = w_pop || (r_res_valid && !res_ready);
  assign w_hold          = r_res_valid && !res_ready;

  // Tracking FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Tracking FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_push) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_hold)                                w_state_nxt = ST_STALL;
        else if (!w_res_valid_nxt && w_empty_nxt)  w_state_nxt = ST_IDLE;
      end
      ST_STALL: begin
        if (res_ready) begin
          if (!w_res_valid_nxt && w_empty_nxt) w_state_nxt = ST_IDLE;
          else                                 w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] r_op_count;

  // Saturating count of completed result handshakes.
  always_ff @(posedge clk) begin
    if (rst)
      r_op_count <= '0;
    else if (r_res_valid && res_ready && (r_op_count != 16'hFFFF))
      r_op_count <= r_op_count + 16'd1;
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue with a behavioural ALU on A/B/Sel.
// Build with ALU_ISSUE_STATS_EN to also exercise op_count.
module tb_alu_issue_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_A;
  logic [7:0]        in_B;
  logic [2:0]        in_Sel;
  logic [7:0]        A;
  logic [7:0]        B;
  logic [2:0]        Sel;
  logic [15:0]       Y;
  logic              Cout;
  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_Y;
  logic              res_Cout;
  logic [2:0]        res_Sel;
  logic [TAG_W-1:0]  res_tag;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0]       op_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0]      y;
    logic             c;
    logic [2:0]       sel;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             sb[$];
  logic [TAG_W-1:0] tb_tag;

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
`ifdef ALU_ISSUE_STATS_EN
    .op_count  (op_count),
`endif
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_A      (in_A),
    .in_B      (in_B),
    .in_Sel    (in_Sel),
    .A         (A),
    .B         (B),
    .Sel       (Sel),
    .Y         (Y),
    .Cout      (Cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_Y     (res_Y),
    .res_Cout  (res_Cout),
    .res_Sel   (res_Sel),
    .res_tag   (res_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: {Cout, Y}
  function automatic logic [16:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] s);
    logic [8:0] t;
    t = '0;
    case (s)
      3'd0: return {1'b0, 8'h00, ~a};
      3'd1: return {1'b0, 8'h00, a | b};
      3'd2: return {1'b0, 8'h00, a & b};
      3'd3: return {1'b0, 8'h00, a ^ b};
      3'd4: begin t = {1'b0, a} + {1'b0, b}; return {t[8], 8'h00, t[7:0]}; end
      3'd5: begin t = {1'b0, a} - {1'b0, b}; return {t[8], 8'h00, t[7:0]}; end
      3'd6: return {1'b0, 16'(a) * 16'(b)};
      default: return {1'b0, 8'h00, ~b};
    endcase
  endfunction

  always_comb {Cout, Y} = alu_f(A, B, Sel);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    exp_t       e;
    logic [16:0] r;
    r     = alu_f(a, b, s);
    e.y   = r[15:0];
    e.c   = r[16];
    e.sel = s;
    e.tag = tb_tag;
    sb.push_back(e);
    tb_tag = tb_tag + TAG_W'(1);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    in_valid = 1'b1; in_A = a; in_B = b; in_Sel = s;
    while (!acc && n < 64) begin
      acc = in_ready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (acc) expect_push(a, b, s);
    else begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    tb_tag = '0;
  endtask

  // Monitor: compares each handshake about to complete on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst && res_valid && res_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_result: got tag %0d Y 0x%0h, required no result", res_tag, res_Y);
      end else begin
        e = sb.pop_front();
        if (res_Y !== e.y || res_Cout !== e.c || res_Sel !== e.sel || res_tag !== e.tag) begin
          n_errors++;
          $display("FAIL result: got Y=0x%0h C=%0b Sel=%0d tag=%0d required Y=0x%0h C=%0b Sel=%0d tag=%0d",
                   res_Y, res_Cout, res_Sel, res_tag, e.y, e.c, e.sel, e.tag);
        end
      end
    end
  end

  initial begin
    int vcnt;
    rst = 1'b1; in_valid = 1'b0; in_A = '0; in_B = '0; in_Sel = '0; res_ready = 1'b0;
    tb_tag = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_Y",     32'(res_Y),     32'd0);
    chk("rst_res_tag",   32'(res_tag),   32'd0);
    chk("rst_res_Sel",   32'(res_Sel),   32'd0);
    chk("rst_A",         32'(A),         32'd0);
    chk("rst_Sel",       32'(Sel),       32'd0);

    // Single ADD: latency and captured values
    res_ready = 1'b1;
    send(8'd8, 8'd4, 3'b100);
    chk("lat_not_yet", 32'(res_valid), 32'd0);
    chk("head_A",      32'(A),         32'd8);
    chk("head_B",      32'(B),         32'd4);
    chk("head_Sel",    32'(Sel),       32'd4);
    @(negedge clk);
    chk("lat_valid",   32'(res_valid), 32'd1);
    chk("add_Y",       32'(res_Y),     32'd12);
    chk("add_Cout",    32'(res_Cout),  32'd0);
    chk("add_tag",     32'(res_tag),   32'd0);
    chk("empty_A",     32'(A),         32'd0);
    drain();

    // Back-pressure: one held result plus a full FIFO
    do_reset();
    res_ready = 1'b0;
    send(8'h01, 8'h02, 3'b001);
    send(8'hF0, 8'h3C, 3'b010);
    send(8'hAA, 8'h55, 3'b011);
    send(8'd200, 8'd100, 3'b100);
    send(8'd5, 8'd9, 3'b101);
    chk("bp_full",      32'(in_ready),  32'd0);
    chk("bp_valid",     32'(res_valid), 32'd1);
    repeat (3) @(negedge clk);
    chk("bp_hold_tag",  32'(res_tag),   32'd0);
    chk("bp_hold_Y",    32'(res_Y),     32'h3);
    chk("bp_hold_Sel",  32'(res_Sel),   32'd1);
    chk("bp_still_full",32'(in_ready),  32'd0);
    res_ready = 1'b1;
    drain();
    chk("bp_ready_after", 32'(in_ready), 32'd1);

    // Streaming: eight opcodes back to back
    do_reset();
    res_ready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_A = 8'd2; in_B = 8'd10; in_Sel = 3'(i);
      chk("stream_ready", 32'(in_ready), 32'd1);
      expect_push(8'd2, 8'd10, 3'(i));
      @(negedge clk);
      if (res_valid) vcnt++; else vcnt = 0;
    end
    in_valid = 1'b0;
    @(negedge clk);
    if (res_valid) vcnt++; else vcnt = 0;
    chk("stream_run_len", 32'(vcnt), 32'd8);
    @(negedge clk);
    chk("stream_end", 32'(res_valid), 32'd0);
    drain();

    // Tag wrap: 17 commands, the last carries tag 0
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(8'(i), 8'd3, 3'b110);
    chk("wrap_tb_tag", 32'(tb_tag), 32'd1);
    drain();

    // Reset mid-stream with queued commands and a held result
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(i + 1), 8'd1, 3'b100);
    chk("mid_valid_before", 32'(res_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    tb_tag = '0;
    chk("mid_res_valid", 32'(res_valid), 32'd0);
    chk("mid_in_ready",  32'(in_ready),  32'd1);
    chk("mid_A",         32'(A),         32'd0);
    res_ready = 1'b1;
    send(8'd7, 8'd7, 3'b100);
    drain();

`ifdef ALU_ISSUE_STATS_EN
    do_reset();
    chk("stat_rst", 32'(op_count), 32'd0);
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(8'(i), 8'd1, 3'b001);
    drain();
    @(negedge clk);
    chk("stat_three", 32'(op_count), 32'd3);
    res_ready = 1'b0;
    send(8'd1, 8'd1, 3'b010);
    send(8'd2, 8'd2, 3'b010);
    repeat (3) @(negedge clk);
    chk("stat_stalled", 32'(op_count), 32'd3);
    res_ready = 1'b1;
    drain();
`endif

    repeat (2) @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
